// File: rtl/axis_deadlock_watchdog.sv
// Purpose : stall watchdog; qualifies a blocked condition, counts consecutive blocked
//           cycles, declares a sticky deadlock at THRESH and keeps stall statistics.
// Latency : 1 cycle, all outputs registered. Backpressure: none, pure observer.
//
// Ports:
//   kernel_monitor_clock  single clock, rising edge
//   kernel_monitor_reset  synchronous active-high reset
//   axis_block_sigs       per-channel blocked flags (bit i = channel i blocked)
//   inst_block_sigs       per-instance blocked flags
//   inst_idle_sigs        per-instance idle flags; all idle suppresses the block
//   clear                 synchronous clear of state and statistics (beats blk)
//   deadlock              sticky deadlock flag
//   deadlock_cause        axis_block_sigs captured when deadlock was declared
//   stall_cycles          length of current/last stall (saturating)
//   max_stall             longest stall since reset/clear (saturating)
//   stall_events          number of stalls started since reset/clear (saturating)
module axis_deadlock_watchdog #(
    parameter int N_AXIS = 2,
    parameter int N_INST = 1,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic              clear,
    output logic              deadlock,
    output logic [N_AXIS-1:0] deadlock_cause,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  max_stall,
    output logic [CNT_W-1:0]  stall_events
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(THRESH);

    // ------------------------------------------------------------------
    // State and statistics registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_deadlock;
    logic [N_AXIS-1:0]   r_deadlock_cause;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_max_stall;
    logic [CNT_W-1:0]    r_stall_events;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              w_nxt_state;
    logic                w_nxt_deadlock;
    logic [N_AXIS-1:0]   w_nxt_deadlock_cause;
    logic [CNT_W-1:0]    w_nxt_stall_cycles;
    logic [CNT_W-1:0]    w_nxt_max_stall;
    logic [CNT_W-1:0]    w_nxt_stall_events;

    logic                w_blk;
    logic [CNT_W-1:0]    w_stall_cycles_inc;
    logic [CNT_W-1:0]    w_stall_events_inc;

    // A blocked instance or channel only counts while at least one instance is
    // still active; a fully idle design is not stalled, merely finished.
    assign w_blk = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign w_stall_cycles_inc = (r_stall_cycles == C_MAX) ? r_stall_cycles
                                                          : r_stall_cycles + C_ONE;
    assign w_stall_events_inc = (r_stall_events == C_MAX) ? r_stall_events
                                                          : r_stall_events + C_ONE;

    always_comb begin
        w_nxt_state          = r_state;
        w_nxt_deadlock       = r_deadlock;
        w_nxt_deadlock_cause = r_deadlock_cause;
        w_nxt_stall_cycles   = r_stall_cycles;
        w_nxt_max_stall      = r_max_stall;
        w_nxt_stall_events   = r_stall_events;

        if (clear) begin
            // Clear wins over blk: no stall may start on the clearing edge.
            w_nxt_state          = ST_RUN;
            w_nxt_deadlock       = 1'b0;
            w_nxt_deadlock_cause = '0;
            w_nxt_stall_cycles   = '0;
            w_nxt_max_stall      = '0;
            w_nxt_stall_events   = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_blk) begin
                        w_nxt_state        = ST_STALL;
                        w_nxt_stall_cycles = C_ONE;
                        w_nxt_stall_events = w_stall_events_inc;
                        if (r_max_stall == '0) begin
                            w_nxt_max_stall = C_ONE;
                        end
                    end
                end

                ST_STALL: begin
                    if (w_blk) begin
                        w_nxt_stall_cycles = w_stall_cycles_inc;
                        if (w_stall_cycles_inc > r_max_stall) begin
                            w_nxt_max_stall = w_stall_cycles_inc;
                        end
                        // Threshold is compared against the post-increment count so
                        // that deadlock rises on exactly the THRESH-th blocked edge.
                        if (w_stall_cycles_inc == C_THRESH) begin
                            w_nxt_state          = ST_DEAD;
                            w_nxt_deadlock       = 1'b1;
                            w_nxt_deadlock_cause = axis_block_sigs;
                        end
                    end else begin
                        // stall_cycles keeps the length of the stall just ended.
                        w_nxt_state = ST_RUN;
                    end
                end

                ST_DEAD: begin
                    // Sticky: everything holds until clear or reset.
                    w_nxt_state = ST_DEAD;
                end

                default: begin
                    w_nxt_state = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            r_state          <= ST_RUN;
            r_deadlock       <= 1'b0;
            r_deadlock_cause <= '0;
            r_stall_cycles   <= '0;
            r_max_stall      <= '0;
            r_stall_events   <= '0;
        end else begin
            r_state          <= w_nxt_state;
            r_deadlock       <= w_nxt_deadlock;
            r_deadlock_cause <= w_nxt_deadlock_cause;
            r_stall_cycles   <= w_nxt_stall_cycles;
            r_max_stall      <= w_nxt_max_stall;
            r_stall_events   <= w_nxt_stall_events;
        end
    end

    assign deadlock       = r_deadlock;
    assign deadlock_cause = r_deadlock_cause;
    assign stall_cycles   = r_stall_cycles;
    assign max_stall      = r_max_stall;
    assign stall_events   = r_stall_events;

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// Purpose : self-checking bench for axis_deadlock_watchdog; two instances
//           (THRESH=4/CNT_W=16 and THRESH=15/CNT_W=4) driven by directed vectors.
// Latency : expectations are queued after each stimulus edge and compared on the next falling edge.
module tb_axis_deadlock_watchdog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: THRESH=4, CNT_W=16
    logic        a_rst, a_clr;
    logic [1:0]  a_axis;
    logic [0:0]  a_iblk, a_idle;
    logic        a_dl;
    logic [1:0]  a_cause;
    logic [15:0] a_sc, a_ms, a_se;

    // Instance B: THRESH=15, CNT_W=4
    logic        b_rst, b_clr;
    logic [1:0]  b_axis;
    logic [0:0]  b_iblk, b_idle;
    logic        b_dl;
    logic [1:0]  b_cause;
    logic [3:0]  b_sc, b_ms, b_se;

    axis_deadlock_watchdog #(.N_AXIS(2), .N_INST(1), .THRESH(4), .CNT_W(16)) u_dut_a (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (a_rst),
        .axis_block_sigs      (a_axis),
        .inst_block_sigs      (a_iblk),
        .inst_idle_sigs       (a_idle),
        .clear                (a_clr),
        .deadlock             (a_dl),
        .deadlock_cause       (a_cause),
        .stall_cycles         (a_sc),
        .max_stall            (a_ms),
        .stall_events         (a_se)
    );

    axis_deadlock_watchdog #(.N_AXIS(2), .N_INST(1), .THRESH(15), .CNT_W(4)) u_dut_b (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (b_rst),
        .axis_block_sigs      (b_axis),
        .inst_block_sigs      (b_iblk),
        .inst_idle_sigs       (b_idle),
        .clear                (b_clr),
        .deadlock             (b_dl),
        .deadlock_cause       (b_cause),
        .stall_cycles         (b_sc),
        .max_stall            (b_ms),
        .stall_events         (b_se)
    );

    typedef struct {
        bit          sel;     // 0 = instance A, 1 = instance B
        string       name;
        logic        dl;
        logic [1:0]  cause;
        logic [15:0] sc;
        logic [15:0] ms;
        logic [15:0] se;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        else
            n_passed++;
    endtask

    // Monitor: outputs are registered and stable between rising edges, so every
    // expectation queued after an edge is compared on the following falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel) begin
                chk(e.name, "deadlock",       {15'd0, a_dl},    {15'd0, e.dl});
                chk(e.name, "deadlock_cause", {14'd0, a_cause}, {14'd0, e.cause});
                chk(e.name, "stall_cycles",   a_sc, e.sc);
                chk(e.name, "max_stall",      a_ms, e.ms);
                chk(e.name, "stall_events",   a_se, e.se);
            end else begin
                chk(e.name, "deadlock",       {15'd0, b_dl},    {15'd0, e.dl});
                chk(e.name, "deadlock_cause", {14'd0, b_cause}, {14'd0, e.cause});
                chk(e.name, "stall_cycles",   {12'd0, b_sc}, e.sc);
                chk(e.name, "max_stall",      {12'd0, b_ms}, e.ms);
                chk(e.name, "stall_events",   {12'd0, b_se}, e.se);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit sel, input string nm, input logic dl, input logic [1:0] c,
                        input int sc, input int ms, input int se);
        exp_t e;
        e.sel = sel; e.name = nm; e.dl = dl; e.cause = c;
        e.sc = 16'(sc); e.ms = 16'(ms); e.se = 16'(se);
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_axis = 2'b00; a_iblk = 1'b0; a_idle = 1'b0;
        b_rst = 1'b1; b_clr = 1'b0; b_axis = 2'b00; b_iblk = 1'b0; b_idle = 1'b0;

        // ---------------- Reset values ----------------
        step(2);
        push(0, "a_reset", 1'b0, 2'b00, 0, 0, 0);
        push(1, "b_reset", 1'b0, 2'b00, 0, 0, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        step(10);
        push(0, "a_idle10", 1'b0, 2'b00, 0, 0, 0);

        // ---------------- Short stall ----------------
        a_axis = 2'b01;
        step(1);
        push(0, "short_e1", 1'b0, 2'b00, 1, 1, 1);
        step(2);
        push(0, "short_e3", 1'b0, 2'b00, 3, 3, 1);
        a_axis = 2'b00;
        step(1);
        push(0, "short_end", 1'b0, 2'b00, 3, 3, 1);
        step(3);
        push(0, "short_hold", 1'b0, 2'b00, 3, 3, 1);

        // ---------------- Deadlock declared ----------------
        a_axis = 2'b10;
        step(1);
        push(0, "dead_e1", 1'b0, 2'b00, 1, 3, 2);
        step(2);
        push(0, "dead_e3", 1'b0, 2'b00, 3, 3, 2);
        step(1);
        push(0, "dead_e4", 1'b1, 2'b10, 4, 4, 2);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v = 4'(i);
            a_axis = v[1:0];
            a_idle = v[2];
            a_iblk = v[3];
            step(1);
            if ((i % 5) == 4) push(0, "dead_sticky", 1'b1, 2'b10, 4, 4, 2);
        end

        // ---------------- Clear priority ----------------
        a_idle = 1'b0; a_iblk = 1'b0;
        a_clr = 1'b1; a_axis = 2'b11;
        step(1);
        push(0, "clear_dead", 1'b0, 2'b00, 0, 0, 0);
        a_clr = 1'b0; a_axis = 2'b01;
        step(1);
        push(0, "clear_restart", 1'b0, 2'b00, 1, 1, 1);
        a_axis = 2'b00;
        step(1);

        // ---------------- Idle suppression and restart ----------------
        a_clr = 1'b1;
        step(1);
        push(0, "clear_idle", 1'b0, 2'b00, 0, 0, 0);
        a_clr = 1'b0;
        a_idle = 1'b1; a_axis = 2'b11;
        step(10);
        push(0, "idle_suppress", 1'b0, 2'b00, 0, 0, 0);
        a_idle = 1'b0;
        step(2);
        push(0, "idle_blk2", 1'b0, 2'b00, 2, 2, 1);
        a_axis = 2'b00;
        step(1);
        push(0, "idle_free", 1'b0, 2'b00, 2, 2, 1);
        a_axis = 2'b11;
        step(1);
        push(0, "idle_restart", 1'b0, 2'b00, 1, 2, 2);
        step(1);
        a_axis = 2'b00;
        step(1);
        push(0, "idle_end", 1'b0, 2'b00, 2, 2, 2);
        a_iblk = 1'b1;
        step(1);
        push(0, "inst_blk", 1'b0, 2'b00, 1, 2, 3);
        a_idle = 1'b1;
        step(1);
        push(0, "inst_blk_idle", 1'b0, 2'b00, 1, 2, 3);
        a_iblk = 1'b0; a_idle = 1'b0;

        // ---------------- Reset in DEAD ----------------
        a_axis = 2'b10;
        step(4);
        push(0, "dead_again", 1'b1, 2'b10, 4, 4, 4);
        a_rst = 1'b1;
        step(1);
        push(0, "reset_dead", 1'b0, 2'b00, 0, 0, 0);
        a_rst = 1'b0; a_axis = 2'b00;
        step(1);
        push(0, "after_reset", 1'b0, 2'b00, 0, 0, 0);

        // ---------------- Saturation (instance B) ----------------
        for (int k = 1; k <= 20; k++) begin
            b_axis = 2'b01;
            step(1);
            b_axis = 2'b00;
            step(1);
            if (k == 3 || k == 15 || k == 20)
                push(1, "b_events_sat", 1'b0, 2'b00, 1, 1, (k > 15) ? 15 : k);
        end
        b_axis = 2'b01;
        step(7);
        push(1, "b_stall7", 1'b0, 2'b00, 7, 7, 15);
        b_rst = 1'b1;
        step(1);
        push(1, "b_reset_mid", 1'b0, 2'b00, 0, 0, 0);
        b_rst = 1'b0; b_axis = 2'b00;
        step(3);
        push(1, "b_after_reset", 1'b0, 2'b00, 0, 0, 0);
        b_axis = 2'b01;
        step(14);
        push(1, "b_stall14", 1'b0, 2'b00, 14, 14, 1);
        step(1);
        push(1, "b_dead15", 1'b1, 2'b01, 15, 15, 1);
        step(2);
        push(1, "b_dead_hold", 1'b1, 2'b01, 15, 15, 1);
        b_axis = 2'b00;

        step(2);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
